// File: rtl/heepidermis_pad_pkg.sv
// Shared types and defaults for the pad input path.
// Interrupt edge selection and synchroniser depth.
package heepidermis_pad_pkg;

    typedef enum logic [1:0] {
        IRQ_NONE = 2'b00,
        IRQ_RISE = 2'b01,
        IRQ_FALL = 2'b10,
        IRQ_BOTH = 2'b11
    } irq_mode_e;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned DEFAULT_CNT_WIDTH   = 16;

    function automatic logic irq_hit(
        input irq_mode_e mode,
        input logic      rise,
        input logic      fall
    );
        logic w_hit;
        w_hit = 1'b0;
        unique case (mode)
            IRQ_NONE: w_hit = 1'b0;
            IRQ_RISE: w_hit = rise;
            IRQ_FALL: w_hit = fall;
            IRQ_BOTH: w_hit = rise | fall;
        endcase
        return w_hit;
    endfunction

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchroniser for an asynchronous pad value.
// Isolated so a technology synchroniser cell can replace it.
module pad_sync
    import heepidermis_pad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pad_input_filter.sv
// Synchronised, debounced pad input with edge strobes and a
// sticky maskable interrupt.
module pad_input_filter
    import heepidermis_pad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pad_in_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] debounce_cycles_i,
    input  logic [1:0]           irq_mode_i,
    input  logic                 irq_clear_i,
    output logic                 level_o,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic                 irq_o
);

    logic                 w_s;
    logic                 w_irq_set;
    logic                 r_level;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_irq;
    logic [CNT_WIDTH-1:0] r_cnt;

    pad_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (pad_in_i),
        .q_o  (w_s)
    );

    // >= lets a lowered threshold commit at once and bounds the counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!en_i || (w_s == r_level)) begin
                r_cnt <= '0;
            end else if (r_cnt >= debounce_cycles_i) begin
                r_level <= w_s;
                r_cnt   <= '0;
                r_rise  <= w_s;
                r_fall  <= ~w_s;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign w_irq_set = irq_hit(irq_mode_e'(irq_mode_i), r_rise, r_fall);

    // Set has priority over clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_clear_i) begin
            r_irq <= 1'b0;
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;
    assign irq_o   = r_irq;

endmodule
